// File: rtl/menu_draw_char_pkg.sv
// Shared constants and types for the menu text-rendering stage.
package menu_draw_char_pkg;

    localparam int unsigned CHAR_W      = 8;
    localparam int unsigned CHAR_H      = 16;
    localparam int unsigned FONT_ADDR_W = 11;

    // One pixel's worth of VGA timing plus background colour; the delay-line element.
    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_bus_t;

endpackage

// File: rtl/menu_draw_char_font_rom.sv
// Synchronous 2048x8 font ROM: address {char_code, line}, MSB is the leftmost pixel.
// Glyph table holds 'A' (0x41) and a solid block (0x7F); every other code, including 0, is blank.
module menu_draw_char_font_rom
    import menu_draw_char_pkg::*;
(
    input  logic                   clk,
    input  logic [FONT_ADDR_W-1:0] addr,
    output logic [7:0]             char_line_pixels
);

    logic [7:0] rom_data;

    // Glyph lookup.
    always_comb begin
        rom_data = 8'h00;
        if (addr[10:4] == 7'h7F) begin
            rom_data = 8'hFF;
        end else if (addr[10:4] == 7'h41) begin
            case (addr[3:0])
                4'd2:    rom_data = 8'h10;
                4'd3:    rom_data = 8'h38;
                4'd4:    rom_data = 8'h6C;
                4'd5:    rom_data = 8'hC6;
                4'd6:    rom_data = 8'hC6;
                4'd7:    rom_data = 8'hFE;
                4'd8:    rom_data = 8'hC6;
                4'd9:    rom_data = 8'hC6;
                4'd10:   rom_data = 8'hC6;
                4'd11:   rom_data = 8'hC6;
                default: rom_data = 8'h00;
            endcase
        end
    end

    // Registered read port; data is not reset, the pipeline gates it with in_box.
    always_ff @(posedge clk) begin
        char_line_pixels <= rom_data;
    end

endmodule

// File: rtl/menu_draw_char.sv
// Text overlay stage: derives the character cell from the VGA stream, fetches the glyph row
// for the returned char code and overlays text onto the delayed background.
module menu_draw_char
    import menu_draw_char_pkg::*;
#(
    parameter logic [10:0] X_POS    = 11'd100,
    parameter logic [10:0] Y_POS    = 11'd100,
    parameter int unsigned COLS     = 16,
    parameter int unsigned ROWS     = 16,
    parameter int unsigned CHAR_LAT = 2,
    parameter logic [11:0] TEXT_RGB = 12'hFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [7:0]  char_xy,
    output logic [3:0]  char_line,
    input  logic [6:0]  char_code_in,
    input  logic [3:0]  char_line_ret,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam int unsigned L = CHAR_LAT + 3;
    localparam logic [10:0] X_END = X_POS + 11'(CHAR_W * COLS);
    localparam logic [10:0] Y_END = Y_POS + 11'(CHAR_H * ROWS);

    // Only the low bits of the relative position are ever needed.
    logic [6:0] rel_x;
    logic [7:0] rel_y;
    logic       in_box;

    logic [7:0] char_xy_q, char_xy_d;
    logic [3:0] char_line_q, char_line_d;
    logic       in_box_q;
    logic [2:0] bit_idx_q;

    // {in_box, bit_idx}; one extra slot lines up with the registered ROM read.
    logic [3:0] meta_q [CHAR_LAT+1];

    vga_bus_t   in_bus;
    vga_bus_t   dly_q [L-1];
    vga_bus_t   out_q, out_d;

    logic [7:0] font_data;
    logic       in_box_d;
    logic [2:0] bit_idx_d;
    logic       pixel;

    // Cell geometry of the incoming pixel.
    always_comb begin
        rel_x       = 7'(hcount_in - X_POS);
        rel_y       = 8'(vcount_in - Y_POS);
        in_box      = (hcount_in >= X_POS) && (hcount_in < X_END) &&
                      (vcount_in >= Y_POS) && (vcount_in < Y_END);
        char_xy_d   = in_box ? {rel_y[7:4], rel_x[6:3]} : 8'h00;
        char_line_d = in_box ? rel_y[3:0] : 4'h0;
        in_bus      = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                        vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
    end

    // S1 registers plus the in_box/bit-index shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            char_xy_q   <= '0;
            char_line_q <= '0;
            in_box_q    <= 1'b0;
            bit_idx_q   <= '0;
            for (int i = 0; i <= int'(CHAR_LAT); i++) meta_q[i] <= '0;
        end else begin
            char_xy_q   <= char_xy_d;
            char_line_q <= char_line_d;
            in_box_q    <= in_box;
            bit_idx_q   <= rel_x[2:0];
            meta_q[0]   <= {in_box_q, bit_idx_q};
            for (int i = 1; i <= int'(CHAR_LAT); i++) meta_q[i] <= meta_q[i-1];
        end
    end

    // Timing/colour delay line, L-1 deep; the output register is the final stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(L) - 1; i++) dly_q[i] <= '0;
            out_q <= '0;
        end else begin
            dly_q[0] <= in_bus;
            for (int i = 1; i < int'(L) - 1; i++) dly_q[i] <= dly_q[i-1];
            out_q <= out_d;
        end
    end

    menu_draw_char_font_rom u_font_rom (
        .clk              (clk),
        .addr             ({char_code_in, char_line_ret}),
        .char_line_pixels (font_data)
    );

    // Pixel select and overlay; blanking wins over text.
    always_comb begin
        in_box_d  = meta_q[CHAR_LAT][3];
        bit_idx_d = meta_q[CHAR_LAT][2:0];
        pixel     = font_data[3'd7 - bit_idx_d];
        out_d     = dly_q[L-2];
        if (dly_q[L-2].hblnk || dly_q[L-2].vblnk) begin
            out_d.rgb = 12'h000;
        end else if (in_box_d && pixel) begin
            out_d.rgb = TEXT_RGB;
        end
    end

    assign char_xy    = char_xy_q;
    assign char_line  = char_line_q;
    assign hcount_out = out_q.hcount;
    assign vcount_out = out_q.vcount;
    assign hsync_out  = out_q.hsync;
    assign vsync_out  = out_q.vsync;
    assign hblnk_out  = out_q.hblnk;
    assign vblnk_out  = out_q.vblnk;
    assign rgb_out    = out_q.rgb;

endmodule
